// File: rtl/scr1_dmem_responder_if.sv
// rtl/scr1_dmem_responder_if.sv - dmem bus types and request/response interface
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_dmem_pkg;
  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

interface scr1_dmem_responder_if;
  logic                               dmem_req_i;
  scr1_dmem_pkg::type_scr1_mem_cmd_e   dmem_cmd_i;
  scr1_dmem_pkg::type_scr1_mem_width_e dmem_width_i;
  logic [`SCR1_DMEM_AWIDTH-1:0]       dmem_addr_i;
  logic [`SCR1_DMEM_DWIDTH-1:0]       dmem_wdata_i;
  logic                               dmem_req_ack_o;
  logic [`SCR1_DMEM_DWIDTH-1:0]       dmem_rdata_o;
  scr1_dmem_pkg::type_scr1_mem_resp_e  dmem_resp_o;

  // initiator side (core LSU)
  modport master (
    output dmem_req_i, dmem_cmd_i, dmem_width_i, dmem_addr_i, dmem_wdata_i,
    input  dmem_req_ack_o, dmem_rdata_o, dmem_resp_o
  );

  // responder side (memory)
  modport slave (
    input  dmem_req_i, dmem_cmd_i, dmem_width_i, dmem_addr_i, dmem_wdata_i,
    output dmem_req_ack_o, dmem_rdata_o, dmem_resp_o
  );
endinterface

// File: rtl/scr1_dmem_responder.sv
// rtl/scr1_dmem_responder.sv - single-port data memory responder; SCR1_DMEM_RESP_STALL_EN adds a response stall
module scr1_dmem_responder
  import scr1_dmem_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  scr1_dmem_responder_if.slave dmem
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  logic [31:0]         mem [MEM_WORDS];
  logic [1:0]          state;
  type_scr1_mem_resp_e resp_q;
  logic [31:0]         rdata_q;

  logic                accept;
  logic                is_wr;
  logic [31:0]         off;
  logic [IDX_W-1:0]    idx;
  logic [1:0]          boff;
  logic                misalign;
  logic                range_err;
  logic                err;
  logic [3:0]          be;
  logic [31:0]         wsh;
  logic [31:0]         rword;
  logic [31:0]         rsh;
  logic [31:0]         rext;

  // ack is combinational so a held request is taken in IDLE and straight out of RESP
  assign dmem.dmem_req_ack_o = rst_n & dmem.dmem_req_i & (state != ST_WAIT);
  assign accept = dmem.dmem_req_ack_o;
  assign is_wr  = (dmem.dmem_cmd_i == SCR1_MEM_CMD_WR);

  // wrap-around subtraction makes addresses below the base land far out of range
  assign off       = dmem.dmem_addr_i - BASE_ADDR;
  assign range_err = ({1'b0, off} >= MEM_BYTES);
  assign idx       = off[IDX_W+1:2];
  assign boff      = dmem.dmem_addr_i[1:0];
  assign err       = misalign | range_err;

  assign wsh   = dmem.dmem_wdata_i << {boff, 3'b000};
  assign rword = mem[idx];
  assign rsh   = rword >> {boff, 3'b000};

  // alignment check, write lane enables and read zero-extension by access width
  always_comb begin
    misalign = 1'b0;
    be       = 4'b0000;
    rext     = 32'h0;
    case (dmem.dmem_width_i)
      SCR1_MEM_WIDTH_BYTE: begin
        be   = 4'b0001 << boff;
        rext = {24'h0, rsh[7:0]};
      end
      SCR1_MEM_WIDTH_HWORD: begin
        misalign = boff[0];
        be       = 4'b0011 << boff;
        rext     = {16'h0, rsh[15:0]};
      end
      SCR1_MEM_WIDTH_WORD: begin
        misalign = (boff != 2'b00);
        be       = 4'b1111;
        rext     = rsh;
      end
      default: begin
        misalign = 1'b1;
      end
    endcase
  end

  // array write on the accept edge; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (accept && is_wr && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wsh[8*i +: 8];
        end
      end
    end
  end

`ifdef SCR1_DMEM_RESP_STALL_EN
  logic [3:0] wait_cnt;

  // control FSM with a stall countdown between accept and response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      resp_q   <= SCR1_MEM_RESP_NOTRDY;
      rdata_q  <= 32'h0;
      wait_cnt <= 4'd0;
    end else if (accept) begin
      resp_q   <= err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      rdata_q  <= (err || is_wr) ? 32'h0 : rext;
      state    <= ST_WAIT;
      wait_cnt <= 4'(WAIT_CYCLES);
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 4'd1) begin
            state    <= ST_RESP;
            wait_cnt <= 4'd0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  logic unused_wait_cycles;
  assign unused_wait_cycles = ^WAIT_CYCLES;

  // control FSM: response always lands in the cycle right after accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      resp_q  <= SCR1_MEM_RESP_NOTRDY;
      rdata_q <= 32'h0;
    end else if (accept) begin
      resp_q  <= err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      rdata_q <= (err || is_wr) ? 32'h0 : rext;
      state   <= ST_RESP;
    end else begin
      state   <= ST_IDLE;
    end
  end
`endif

  assign dmem.dmem_resp_o  = (state == ST_RESP) ? resp_q : SCR1_MEM_RESP_NOTRDY;
  assign dmem.dmem_rdata_o = ((state == ST_RESP) && (resp_q == SCR1_MEM_RESP_RDY_OK))
                             ? rdata_q : 32'h0;

endmodule

// File: tb/tb_scr1_dmem_responder.sv
// tb/tb_scr1_dmem_responder.sv - scoreboard bench for scr1_dmem_responder
module tb_scr1_dmem_responder;
  import scr1_dmem_pkg::*;

  localparam int          MEM_WORDS   = 64;
  localparam logic [31:0] BASE_ADDR   = 32'h0000_0000;
  localparam int          WAIT_CYCLES = 3;
`ifdef SCR1_DMEM_RESP_STALL_EN
  localparam int LAT = WAIT_CYCLES + 1;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    type_scr1_mem_resp_e resp;
    logic [31:0]         rdata;
    int                  cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];
  logic [31:0] mdl [MEM_WORDS];

  scr1_dmem_responder_if dmem_if ();

  scr1_dmem_responder #(
    .MEM_WORDS  (MEM_WORDS),
    .BASE_ADDR  (BASE_ADDR),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dmem (dmem_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // reference model of one access; updates mdl for valid writes
  task automatic model_access(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e w,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output type_scr1_mem_resp_e resp, output logic [31:0] rd);
    logic [31:0] o;
    logic [31:0] word;
    logic        bad;
    int          ix;
    o   = addr - BASE_ADDR;
    bad = (o >= MEM_WORDS * 4);
    case (w)
      SCR1_MEM_WIDTH_BYTE:  ;
      SCR1_MEM_WIDTH_HWORD: if (addr[0]) bad = 1'b1;
      SCR1_MEM_WIDTH_WORD:  if (addr[1:0] != 2'b00) bad = 1'b1;
      default:              bad = 1'b1;
    endcase
    resp = SCR1_MEM_RESP_RDY_OK;
    rd   = 32'h0;
    if (bad) begin
      resp = SCR1_MEM_RESP_RDY_ER;
    end else begin
      ix   = int'(o / 4);
      word = mdl[ix];
      if (cmd == SCR1_MEM_CMD_WR) begin
        if (w == SCR1_MEM_WIDTH_WORD) word = wd;
        else if (w == SCR1_MEM_WIDTH_HWORD) begin
          if (addr[1]) word[31:16] = wd[15:0];
          else         word[15:0]  = wd[15:0];
        end else begin
          case (addr[1:0])
            2'd0: word[7:0]   = wd[7:0];
            2'd1: word[15:8]  = wd[7:0];
            2'd2: word[23:16] = wd[7:0];
            default: word[31:24] = wd[7:0];
          endcase
        end
        mdl[ix] = word;
      end else begin
        if (w == SCR1_MEM_WIDTH_WORD) rd = word;
        else if (w == SCR1_MEM_WIDTH_HWORD) rd = addr[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
        else begin
          case (addr[1:0])
            2'd0: rd = {24'h0, word[7:0]};
            2'd1: rd = {24'h0, word[15:8]};
            2'd2: rd = {24'h0, word[23:16]};
            default: rd = {24'h0, word[31:24]};
          endcase
        end
      end
    end
  endtask

  // monitor: pop and compare responses, then push expectations for accepted requests
  always @(negedge clk) begin
    exp_t e;
    type_scr1_mem_resp_e r;
    logic [31:0] d;
    if (rst_n) begin
      if (dmem_if.dmem_resp_o != SCR1_MEM_RESP_NOTRDY) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_resp", 32'(dmem_if.dmem_resp_o), 32'(SCR1_MEM_RESP_NOTRDY));
        end else begin
          e = sb.pop_front();
          check_eq("resp", 32'(dmem_if.dmem_resp_o), 32'(e.resp));
          check_eq("rdata", dmem_if.dmem_rdata_o, e.rdata);
          check_eq("latency", 32'(cyc - e.cyc), 32'(LAT));
        end
      end else begin
        check_eq("rdata_notrdy", dmem_if.dmem_rdata_o, 32'h0);
`ifdef SCR1_DMEM_RESP_STALL_EN
        if (sb.size() > 0 && dmem_if.dmem_req_i) check_eq("ack_in_wait", 32'(dmem_if.dmem_req_ack_o), 32'h0);
`endif
      end
      if (dmem_if.dmem_req_i && dmem_if.dmem_req_ack_o) begin
        model_access(dmem_if.dmem_cmd_i, dmem_if.dmem_width_i, dmem_if.dmem_addr_i,
                     dmem_if.dmem_wdata_i, r, d);
        e.resp = r; e.rdata = d; e.cyc = cyc;
        sb.push_back(e);
      end
    end else begin
      check_eq("ack_in_reset", 32'(dmem_if.dmem_req_ack_o), 32'h0);
      sb.delete();
    end
  end

  // present a request and return #1 after its accept edge with req still high
  task automatic send(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e w,
                      input logic [31:0] addr, input logic [31:0] wd);
    logic got;
    got = 1'b0;
    dmem_if.dmem_req_i   = 1'b1;
    dmem_if.dmem_cmd_i   = cmd;
    dmem_if.dmem_width_i = w;
    dmem_if.dmem_addr_i  = addr;
    dmem_if.dmem_wdata_i = wd;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dmem_if.dmem_req_ack_o) begin
        got = 1'b1;
        break;
      end
    end
    check_eq("ack_seen", 32'(got), 32'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    dmem_if.dmem_req_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int   c0;
    logic seen;
    for (int i = 0; i < MEM_WORDS; i++) mdl[i] = 32'h0;
    dmem_if.dmem_req_i   = 1'b0;
    dmem_if.dmem_cmd_i   = SCR1_MEM_CMD_RD;
    dmem_if.dmem_width_i = SCR1_MEM_WIDTH_WORD;
    dmem_if.dmem_addr_i  = 32'h0;
    dmem_if.dmem_wdata_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    dmem_if.dmem_req_i = 1'b1;
    #1;
    check_eq("rst_resp", 32'(dmem_if.dmem_resp_o), 32'(SCR1_MEM_RESP_NOTRDY));
    check_eq("rst_rdata", dmem_if.dmem_rdata_o, 32'h0);
    check_eq("rst_ack", 32'(dmem_if.dmem_req_ack_o), 32'h0);
    dmem_if.dmem_req_i = 1'b0;
    rst_n = 1'b1;
    idle(2);

    send(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10, 32'hDEADBEEF);
    idle(LAT + 1);
    send(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0);
    idle(LAT + 1);

    send(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h13, 32'h000000AA);
    send(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0);
    send(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h12, 32'h0);
    send(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h10, 32'h0);
    send(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h11, 32'h0);
    send(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h13, 32'h0);
    idle(LAT + 1);

    send(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h02, 32'h0);
    send(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h11, 32'h5555);
    send(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0);
    send(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE_ADDR + 4 * MEM_WORDS - 4, 32'hCAFEF00D);
    send(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE_ADDR + 4 * MEM_WORDS, 32'h12345678);
    send(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE_ADDR + 4 * MEM_WORDS - 4, 32'h0);
    send(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'hFFFF_FFFC, 32'h0);
    send(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h22, 32'h0000_1234);
    send(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h20, 32'h0);
    idle(LAT + 1);

    for (int i = 0; i < 4; i++) send(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h30 + 4 * i, $urandom);
    idle(LAT + 1);
    c0 = cyc;
    for (int i = 0; i < 4; i++) send(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h30 + 4 * i, 32'h0);
    check_eq("burst_cycles", 32'(cyc - c0), 32'(1 + 3 * LAT));
    idle(LAT + 1);

    send(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0);
    dmem_if.dmem_req_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dmem_if.dmem_resp_o != SCR1_MEM_RESP_NOTRDY) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("rst_wait_resp", 32'(seen), 32'h1);
    #2;
    rst_n = 1'b0;
    dmem_if.dmem_req_i = 1'b1;
    #1;
    check_eq("ack_rst_low", 32'(dmem_if.dmem_req_ack_o), 32'h0);
    @(posedge clk);
    #1;
    check_eq("mid_rst_resp", 32'(dmem_if.dmem_resp_o), 32'(SCR1_MEM_RESP_NOTRDY));
    check_eq("mid_rst_rdata", dmem_if.dmem_rdata_o, 32'h0);
    dmem_if.dmem_req_i = 1'b0;
    rst_n = 1'b1;
    idle(1);
    send(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0);
    send(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h30, 32'h0);
    idle(LAT + 3);
    check_eq("sb_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
